// File: rtl/alu_types.sv
// ALU operation encoding shared by decode and execute.
package alu_types;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_SLL     = 4'd2,
        ALU_SLT     = 4'd3,
        ALU_SLTU    = 4'd4,
        ALU_XOR     = 4'd5,
        ALU_SRL     = 4'd6,
        ALU_SRA     = 4'd7,
        ALU_OR      = 4'd8,
        ALU_AND     = 4'd9,
        ALU_INVALID = 4'd15
    } alu_control_t;

endpackage

// File: rtl/decode_pkg.sv
// Instruction classes, opcode/funct7 constants and the decoded-entry payload.
package decode_pkg;
    import alu_types::*;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I_ALU   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_AUIPC   = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } op_class_t;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I_ALU  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded fields that do not depend on XLEN
    typedef struct packed {
        op_class_t    cls;
        alu_control_t alu_op;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   funct3;
        logic         illegal;
    } decode_entry_t;

    localparam decode_entry_t ENTRY_RESET = '{
        cls: CLS_R, alu_op: ALU_ADD, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
        funct3: 3'd0, illegal: 1'b0
    };

    // Base ALU op for a register/immediate arithmetic funct3
    function automatic alu_control_t alu_from_funct3(input logic [2:0] f3);
        alu_control_t op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Combinational instruction decoder: class, ALU op, indices, immediate, legality.
module rv32_decode_comb
    import alu_types::*;
    import decode_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter bit          STRICT_FUNCT7 = 1'b1
) (
    input  logic [31:0]     instr,
    output decode_entry_t   dec_c,
    output logic [XLEN-1:0] imm_c
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alt_bit;
    logic        sh_zero;
    logic        sh_alt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm32;

    // Field extraction and the five immediate formats
    always_comb begin
        opcode  = instr[6:0];
        funct3  = instr[14:12];
        funct7  = instr[31:25];
        alt_bit = instr[30];
        imm_i   = {{20{instr[31]}}, instr[31:20]};
        imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u   = {instr[31:12], 12'b0};
        imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        // RV64 shifts use bit 25 as shamt[5], so only [31:26] qualifies the op
        if (XLEN == 64) begin
            sh_zero = (instr[31:26] == 6'b000000);
            sh_alt  = (instr[31:26] == 6'b010000);
        end else begin
            sh_zero = (funct7 == F7_ZERO);
            sh_alt  = (funct7 == F7_ALT);
        end
    end

    // Per-opcode classification, operand selection and legality
    always_comb begin
        dec_c = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, rd: 5'd0, rs1: 5'd0,
                  rs2: 5'd0, funct3: funct3, illegal: 1'b0};
        imm32 = 32'd0;
        case (opcode)
            OPC_R: begin
                dec_c.cls    = CLS_R;
                dec_c.rd     = instr[11:7];
                dec_c.rs1    = instr[19:15];
                dec_c.rs2    = instr[24:20];
                dec_c.alu_op = alu_from_funct3(funct3);
                if (STRICT_FUNCT7 && funct7 != F7_ZERO && funct7 != F7_ALT) begin
                    dec_c.illegal = 1'b1;
                end else if (alt_bit) begin
                    if (funct3 == 3'b000)      dec_c.alu_op  = ALU_SUB;
                    else if (funct3 == 3'b101) dec_c.alu_op  = ALU_SRA;
                    else                       dec_c.illegal = 1'b1;
                end
            end
            OPC_I_ALU: begin
                dec_c.cls    = CLS_I_ALU;
                dec_c.rd     = instr[11:7];
                dec_c.rs1    = instr[19:15];
                dec_c.alu_op = alu_from_funct3(funct3);
                imm32        = imm_i;
                if (funct3 == 3'b001) begin
                    dec_c.illegal = STRICT_FUNCT7 ? ~sh_zero : alt_bit;
                end else if (funct3 == 3'b101) begin
                    if (STRICT_FUNCT7) begin
                        if (sh_alt)        dec_c.alu_op  = ALU_SRA;
                        else if (!sh_zero) dec_c.illegal = 1'b1;
                    end else if (alt_bit) begin
                        dec_c.alu_op = ALU_SRA;
                    end
                end
            end
            OPC_LOAD: begin
                dec_c.cls     = CLS_LOAD;
                dec_c.rd      = instr[11:7];
                dec_c.rs1     = instr[19:15];
                imm32         = imm_i;
                dec_c.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_c.cls     = CLS_STORE;
                dec_c.rs1     = instr[19:15];
                dec_c.rs2     = instr[24:20];
                imm32         = imm_s;
                dec_c.illegal = funct3[2];
            end
            OPC_BRANCH: begin
                dec_c.cls = CLS_BRANCH;
                dec_c.rs1 = instr[19:15];
                dec_c.rs2 = instr[24:20];
                imm32     = imm_b;
                case (funct3[2:1])
                    2'b00:   dec_c.alu_op  = ALU_SUB;
                    2'b10:   dec_c.alu_op  = ALU_SLT;
                    2'b11:   dec_c.alu_op  = ALU_SLTU;
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_c.cls = CLS_LUI;
                dec_c.rd  = instr[11:7];
                imm32     = imm_u;
            end
            OPC_AUIPC: begin
                dec_c.cls = CLS_AUIPC;
                dec_c.rd  = instr[11:7];
                imm32     = imm_u;
            end
            OPC_JAL: begin
                dec_c.cls = CLS_JAL;
                dec_c.rd  = instr[11:7];
                imm32     = imm_j;
            end
            OPC_JALR: begin
                dec_c.cls     = CLS_JALR;
                dec_c.rd      = instr[11:7];
                dec_c.rs1     = instr[19:15];
                imm32         = imm_i;
                dec_c.illegal = (funct3 != 3'b000);
            end
            default: begin
                dec_c.illegal = 1'b1;
            end
        endcase
        if (dec_c.illegal) begin
            dec_c.alu_op = ALU_INVALID;
        end
        imm_c = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered decode stage: skid-buffered valid/ready pipeline plus illegal counter.
module rv32_decode_stage
    import alu_types::*;
    import decode_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter bit          STRICT_FUNCT7 = 1'b1,
    parameter bit          SKID          = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output op_class_t        out_class,
    output alu_control_t     out_alu_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [15:0]      illegal_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    skid_state_t     state;
    decode_entry_t   dec_c;
    logic [XLEN-1:0] imm_c;
    decode_entry_t   main_q;
    decode_entry_t   skid_q;
    logic [XLEN-1:0] main_imm_q;
    logic [XLEN-1:0] main_pc_q;
    logic [XLEN-1:0] skid_imm_q;
    logic [XLEN-1:0] skid_pc_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic            accept;
    logic            drain;

    rv32_decode_comb #(
        .XLEN          (XLEN),
        .STRICT_FUNCT7 (STRICT_FUNCT7)
    ) u_decode (
        .instr (in_instr),
        .dec_c (dec_c),
        .imm_c (imm_c)
    );

    // Handshake events for this cycle; a flush swallows any input beat
    always_comb begin
        accept = in_valid & in_ready & ~flush;
        drain  = out_valid_q & out_ready;
    end

    // Without the skid entry, ready must look through to the downstream consumer
    assign in_ready = SKID ? in_ready_q : (~out_valid_q | out_ready);

    // Skid FSM, entry registers and saturating illegal counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= ENTRY_RESET;
            skid_q      <= ENTRY_RESET;
            main_imm_q  <= '0;
            main_pc_q   <= '0;
            skid_imm_q  <= '0;
            skid_pc_q   <= '0;
            cnt_q       <= '0;
        end else begin
            if (accept && dec_c.illegal && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (flush) begin
                state       <= ST_EMPTY;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_q      <= dec_c;
                            main_imm_q  <= imm_c;
                            main_pc_q   <= in_pc;
                            state       <= ST_ONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (accept && drain) begin
                            main_q     <= dec_c;
                            main_imm_q <= imm_c;
                            main_pc_q  <= in_pc;
                        end else if (accept) begin
                            skid_q     <= dec_c;
                            skid_imm_q <= imm_c;
                            skid_pc_q  <= in_pc;
                            state      <= ST_FULL;
                            in_ready_q <= 1'b0;
                        end else if (drain) begin
                            state       <= ST_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (drain) begin
                            main_q     <= skid_q;
                            main_imm_q <= skid_imm_q;
                            main_pc_q  <= skid_pc_q;
                            state      <= ST_ONE;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_class     = main_q.cls;
    assign out_alu_op    = main_q.alu_op;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_funct3    = main_q.funct3;
    assign out_illegal   = main_q.illegal;
    assign out_imm       = main_imm_q;
    assign out_pc        = main_pc_q;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Self-checking bench for rv32_decode_stage: directed table, stream sequences, random traffic.
module tb_rv32_decode_stage;
    import alu_types::*;
    import decode_pkg::*;

    localparam int unsigned XLEN = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = 32'd0;
    logic [XLEN-1:0]   in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    op_class_t         out_class;
    alu_control_t      out_alu_op;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [2:0]        out_funct3;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_pc;
    logic              out_illegal;
    logic [15:0]       illegal_count;

    rv32_decode_stage #(.XLEN(XLEN), .STRICT_FUNCT7(1'b1), .SKID(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_class     (out_class),
        .out_alu_op    (out_alu_op),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct3    (out_funct3),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_class_t    cls;
        alu_control_t alu;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   f3;
        logic [31:0]  imm;
        logic [31:0]  pc;
        logic         ill;
    } exp_t;

    typedef struct {
        logic [31:0]  instr;
        op_class_t    cls;
        alu_control_t alu;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [31:0]  imm;
        logic         ill;
        int unsigned  cnt;
    } vec_t;

    exp_t        q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned m_cnt = 0;
    int unsigned n_drain = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA field rules, using integer arithmetic
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        alu_control_t tbl[8];
        int op, f3, f7, rd, rs1, rs2, sgn;
        int imm_i, imm_s, imm_b, imm_u, imm_j;
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        op  = int'(i & 32'h7F);
        f3  = int'((i >> 12) & 32'h7);
        f7  = int'((i >> 25) & 32'h7F);
        rd  = int'((i >> 7) & 32'h1F);
        rs1 = int'((i >> 15) & 32'h1F);
        rs2 = int'((i >> 20) & 32'h1F);
        sgn = i[31] ? -1 : 0;
        imm_i = ($signed(i) >>> 20);
        imm_s = sgn * 4096 + f7 * 32 + rd;
        imm_b = sgn * 4096 + int'((i >> 7) & 1) * 2048 + int'((i >> 25) & 63) * 32
                + int'((i >> 8) & 15) * 2;
        imm_u = int'(i & 32'hFFFFF000);
        imm_j = sgn * 1048576 + int'((i >> 12) & 255) * 4096 + int'((i >> 20) & 1) * 2048
                + int'((i >> 21) & 1023) * 2;
        e = '{cls: CLS_ILLEGAL, alu: ALU_ADD, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
              f3: 3'(f3), imm: 32'd0, pc: pc, ill: 1'b0};
        case (op)
            'h33: begin
                e.cls = CLS_R; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
                if (f7 == 0)                  e.alu = tbl[f3];
                else if (f7 == 32 && f3 == 0) e.alu = ALU_SUB;
                else if (f7 == 32 && f3 == 5) e.alu = ALU_SRA;
                else                          e.ill = 1'b1;
            end
            'h13: begin
                e.cls = CLS_I_ALU; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.imm = 32'(imm_i);
                e.alu = tbl[f3];
                if (f3 == 1 && f7 != 0) e.ill = 1'b1;
                if (f3 == 5) begin
                    if (f7 == 32)     e.alu = ALU_SRA;
                    else if (f7 != 0) e.ill = 1'b1;
                end
            end
            'h03: begin
                e.cls = CLS_LOAD; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.imm = 32'(imm_i);
                e.ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            'h23: begin
                e.cls = CLS_STORE; e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.imm = 32'(imm_s);
                e.ill = (f3 >= 4);
            end
            'h63: begin
                e.cls = CLS_BRANCH; e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.imm = 32'(imm_b);
                if (f3 <= 1)      e.alu = ALU_SUB;
                else if (f3 <= 3) e.ill = 1'b1;
                else if (f3 <= 5) e.alu = ALU_SLT;
                else              e.alu = ALU_SLTU;
            end
            'h37: begin e.cls = CLS_LUI;   e.rd = 5'(rd); e.imm = 32'(imm_u); end
            'h17: begin e.cls = CLS_AUIPC; e.rd = 5'(rd); e.imm = 32'(imm_u); end
            'h6F: begin e.cls = CLS_JAL;   e.rd = 5'(rd); e.imm = 32'(imm_j); end
            'h67: begin
                e.cls = CLS_JALR; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.imm = 32'(imm_i);
                e.ill = (f3 != 0);
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) e.alu = ALU_INVALID;
        return e;
    endfunction

    // One clock: update the model from the handshake seen before the edge, then check after it
    task automatic step();
        bit   acc;
        bit   drn;
        exp_t e;
        acc = (rst === 1'b1) && !flush && in_valid && (in_ready === 1'b1);
        drn = (rst === 1'b1) && (out_valid === 1'b1) && out_ready;
        if (drn && q.size() > 0) begin
            void'(q.pop_front());
            n_drain++;
        end
        if (rst !== 1'b1) begin
            q.delete();
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else if (acc) begin
            e = ref_decode(in_instr, in_pc);
            q.push_back(e);
            if (e.ill && m_cnt < 32'hFFFF) m_cnt++;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("illegal_count", 64'(illegal_count), 64'(m_cnt));
        if (q.size() > 0 && out_valid === 1'b1) begin
            chk("class", 64'(out_class), 64'(q[0].cls));
            chk("alu_op", 64'(out_alu_op), 64'(q[0].alu));
            chk("rd", 64'(out_rd), 64'(q[0].rd));
            chk("rs1", 64'(out_rs1), 64'(q[0].rs1));
            chk("rs2", 64'(out_rs2), 64'(q[0].rs2));
            chk("funct3", 64'(out_funct3), 64'(q[0].f3));
            chk("imm", 64'(out_imm), 64'(q[0].imm));
            chk("pc", 64'(out_pc), 64'(q[0].pc));
            chk("illegal", 64'(out_illegal), 64'(q[0].ill));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[9];
        logic [31:0] r;
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) r[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0:       r[31:25] = 7'h00;
            1:       r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    vec_t tbl[15];
    bit   pat[4];

    initial begin
        tbl[0]  = '{32'h002081B3, CLS_R,       ALU_ADD,     5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 0};
        tbl[1]  = '{32'h40208133, CLS_R,       ALU_SUB,     5'd2, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 0};
        tbl[2]  = '{32'hFFF00093, CLS_I_ALU,   ALU_ADD,     5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 0};
        tbl[3]  = '{32'hFE000EE3, CLS_BRANCH,  ALU_SUB,     5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 0};
        tbl[4]  = '{32'h40109093, CLS_I_ALU,   ALU_INVALID, 5'd1, 5'd1, 5'd0, 32'h0000_0401, 1'b1, 1};
        tbl[5]  = '{32'h123452B7, CLS_LUI,     ALU_ADD,     5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 1};
        tbl[6]  = '{32'hFFDFF0EF, CLS_JAL,     ALU_ADD,     5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 1};
        tbl[7]  = '{32'h0020A423, CLS_STORE,   ALU_ADD,     5'd0, 5'd1, 5'd2, 32'h0000_0008, 1'b0, 1};
        tbl[8]  = '{32'h0000007F, CLS_ILLEGAL, ALU_INVALID, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b1, 2};
        tbl[9]  = '{32'h0000B003, CLS_LOAD,    ALU_INVALID, 5'd0, 5'd1, 5'd0, 32'h0000_0000, 1'b1, 3};
        tbl[10] = '{32'h00009067, CLS_JALR,    ALU_INVALID, 5'd0, 5'd1, 5'd0, 32'h0000_0000, 1'b1, 4};
        tbl[11] = '{32'h4020F1B3, CLS_R,       ALU_INVALID, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b1, 5};
        tbl[12] = '{32'h4030D093, CLS_I_ALU,   ALU_SRA,     5'd1, 5'd1, 5'd0, 32'h0000_0403, 1'b0, 5};
        tbl[13] = '{32'h80000017, CLS_AUIPC,   ALU_ADD,     5'd0, 5'd0, 5'd0, 32'h8000_0000, 1'b0, 5};
        tbl[14] = '{32'h00002063, CLS_BRANCH,  ALU_INVALID, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b1, 6};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_op", 64'(out_alu_op), 64'(ALU_ADD));
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_count", 64'(illegal_count), 64'd0);
        rst = 1'b1;
        step();

        // Directed decode table, one entry per cycle with out_ready high
        out_ready = 1'b1;
        for (int v = 0; v < 15; v++) begin
            logic [31:0] ins;
            ins      = tbl[v].instr;
            in_valid = 1'b1;
            in_instr = ins;
            in_pc    = $urandom;
            step();
            chk("tbl_valid", 64'(out_valid), 64'd1);
            chk("tbl_class", 64'(out_class), 64'(tbl[v].cls));
            chk("tbl_alu", 64'(out_alu_op), 64'(tbl[v].alu));
            chk("tbl_rd", 64'(out_rd), 64'(tbl[v].rd));
            chk("tbl_rs1", 64'(out_rs1), 64'(tbl[v].rs1));
            chk("tbl_rs2", 64'(out_rs2), 64'(tbl[v].rs2));
            chk("tbl_funct3", 64'(out_funct3), 64'(ins[14:12]));
            chk("tbl_imm", 64'(out_imm), 64'(tbl[v].imm));
            chk("tbl_illegal", 64'(out_illegal), 64'(tbl[v].ill));
            chk("tbl_count", 64'(illegal_count), 64'(tbl[v].cnt));
        end
        in_valid = 1'b0;
        step();

        // Stream 8 entries with out_ready cycling 1,0,0,1
        begin
            int sent;
            int d0;
            sent = 0;
            d0   = int'(n_drain);
            for (int c = 0; c < 200 && (sent < 8 || q.size() > 0); c++) begin
                out_ready = pat[c % 4];
                in_valid  = (sent < 8);
                in_instr  = rand_instr();
                in_pc     = 32'(sent * 4);
                if (in_valid && in_ready) sent++;
                step();
            end
            chk("stream_sent", 64'(sent), 64'd8);
            chk("stream_drained", 64'(int'(n_drain) - d0), 64'd8);
        end

        // Full throughput with out_ready held high
        begin
            int acc;
            acc = 0;
            out_ready = 1'b1;
            for (int c = 0; c < 20; c++) begin
                in_valid = 1'b1;
                in_instr = rand_instr();
                in_pc    = $urandom;
                if (in_ready) acc++;
                step();
            end
            chk("throughput", 64'(acc), 64'd20);
            in_valid = 1'b0;
            step();
        end

        // Fill to FULL, then flush together with a valid input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        step();
        in_instr  = 32'h40208133;
        step();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        flush    = 1'b1;
        in_instr = 32'h0000007F;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("flush_discard", 64'(out_valid), 64'd0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            step();
        end
        flush = 1'b0;

        // Reset mid-stream
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_instr  = 32'h0000007F;
        step();
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_count", 64'(illegal_count), 64'd0);
        chk("mid_rst_class", 64'(out_class), 64'd0);
        chk("mid_rst_alu", 64'(out_alu_op), 64'(ALU_ADD));
        chk("mid_rst_rd", 64'(out_rd), 64'd0);
        chk("mid_rst_pc", 64'(out_pc), 64'd0);
        chk("mid_rst_illegal", 64'(out_illegal), 64'd0);
        rst = 1'b1;

        // Saturate the illegal counter
        begin
            int acc;
            acc       = 0;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_instr  = 32'h0000007F;
            for (int c = 0; c < 70000 && acc < 65540; c++) begin
                if (in_ready) acc++;
                step();
            end
            in_valid = 1'b0;
            step();
            chk("sat_accepted", 64'(acc), 64'd65540);
            chk("sat_count", 64'(illegal_count), 64'hFFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
